// File: rtl/sdram_arbiter.sv
// sdram_arbiter: schedules video reads, CPU reads/writes and auto-refresh onto one SDRAM controller,
// one command at a time, and steers returned read data back to the issuing port.
module sdram_arbiter #(
    parameter int FREQ             = 54_000_000,
    parameter int REFRESH_INTERVAL = FREQ / 1_000_000 * 15,
    parameter int ADDR_WIDTH       = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_ack,
    output logic [31:0]           vid_data,
    output logic                  vid_valid,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [15:0]           cpu_din,
    input  logic [31:0]           cpu_din32,
    input  logic [1:0]            cpu_wdm,
    output logic                  cpu_ack,
    output logic [31:0]           cpu_data,
    output logic                  cpu_valid,
    output logic                  sd_rd,
    output logic                  sd_wr,
    output logic                  sd_refresh,
    output logic [ADDR_WIDTH-1:0] sd_addr,
    output logic [15:0]           sd_din,
    output logic [31:0]           sd_din32,
    output logic [1:0]            sd_wdm,
    input  logic [31:0]           sd_dout32,
    input  logic                  sd_data_ready,
    input  logic                  sd_busy,
    input  logic                  sd_enabled
);
    localparam int CW = $clog2(REFRESH_INTERVAL + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_REF, OWN_VID, OWN_CPU} owner_t;

    state_t                r_state, w_next;
    owner_t                r_owner, w_sel;
    logic                  r_we, r_seen_busy, r_vid_valid, r_cpu_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_din;
    logic [31:0]           r_din32, r_vid_data, r_cpu_data;
    logic [1:0]            r_wdm, r_debt;
    logic [CW-1:0]         r_ref_cnt;
    logic                  w_wrap, w_dec, w_go, w_rd_ret;

    assign w_wrap   = r_ref_cnt == CW'(REFRESH_INTERVAL - 1);
    assign w_dec    = r_state == S_ISSUE && r_owner == OWN_REF;
    assign w_go     = sd_enabled && !sd_busy && (r_debt != 2'd0 || vid_req || cpu_req);
    assign w_sel    = r_debt != 2'd0 ? OWN_REF : vid_req ? OWN_VID : OWN_CPU;
    assign w_rd_ret = r_state == S_WAIT && !r_we && sd_data_ready;

    // Refresh timer free-runs even before the controller is enabled; debt saturates at 3.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ref_cnt <= '0;
            r_debt    <= '0;
        end else begin
            r_ref_cnt <= w_wrap ? '0 : r_ref_cnt + CW'(1);
            r_debt    <= (w_wrap && !w_dec && r_debt != 2'd3) ? r_debt + 2'd1 :
                         (w_dec && !w_wrap) ? r_debt - 2'd1 : r_debt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE && w_go) w_next = S_ISSUE;
        if (r_state == S_ISSUE) w_next = S_WAIT;
        if (r_state == S_WAIT && r_seen_busy && !sd_busy) w_next = S_IDLE;
    end

    always_comb begin
        sd_rd      = r_state == S_ISSUE && (r_owner == OWN_VID || (r_owner == OWN_CPU && !r_we));
        sd_wr      = r_state == S_ISSUE && r_owner == OWN_CPU && r_we;
        sd_refresh = r_state == S_ISSUE && r_owner == OWN_REF;
        vid_ack    = r_state == S_ISSUE && r_owner == OWN_VID;
        cpu_ack    = r_state == S_ISSUE && r_owner == OWN_CPU;
    end

    assign sd_addr   = r_addr;
    assign sd_din    = r_din;
    assign sd_din32  = r_din32;
    assign sd_wdm    = r_wdm;
    assign vid_data  = r_vid_data;
    assign vid_valid = r_vid_valid;
    assign cpu_data  = r_cpu_data;
    assign cpu_valid = r_cpu_valid;

    // Grant latch: a refresh keeps the previous address/data on the controller bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= OWN_NONE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_din32 <= '0;
            r_wdm   <= '0;
        end else if (r_state == S_IDLE && w_go) begin
            r_owner <= w_sel;
            r_we    <= w_sel == OWN_CPU && cpu_we;
            r_addr  <= w_sel == OWN_VID ? vid_addr : w_sel == OWN_CPU ? cpu_addr : r_addr;
            r_din   <= w_sel == OWN_CPU ? cpu_din : r_din;
            r_din32 <= w_sel == OWN_CPU ? cpu_din32 : r_din32;
            r_wdm   <= w_sel == OWN_CPU ? cpu_wdm : r_wdm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_seen_busy <= 1'b0;
        else       r_seen_busy <= r_state == S_ISSUE ? 1'b0 : (r_state == S_WAIT && sd_busy) ? 1'b1 : r_seen_busy;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vid_valid <= 1'b0;
            r_cpu_valid <= 1'b0;
            r_vid_data  <= '0;
            r_cpu_data  <= '0;
        end else begin
            r_vid_valid <= w_rd_ret && r_owner == OWN_VID;
            r_cpu_valid <= w_rd_ret && r_owner == OWN_CPU;
            r_vid_data  <= (w_rd_ret && r_owner == OWN_VID) ? sd_dout32 : r_vid_data;
            r_cpu_data  <= (w_rd_ret && r_owner == OWN_CPU) ? sd_dout32 : r_cpu_data;
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed stimulus against a small controller model; a negedge monitor
// pops per-port command/data expectations and tracks a refresh-debt model.
module tb_sdram_arbiter;
    localparam int AW = 23;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic [31:0]   din32;
        logic [1:0]    wdm;
    } cmd_t;

    logic          clk = 1'b0, reset;
    logic          vid_req, vid_ack, vid_valid, cpu_req, cpu_we, cpu_ack, cpu_valid;
    logic [AW-1:0] vid_addr, cpu_addr, sd_addr;
    logic [31:0]   vid_data, cpu_data, cpu_din32, sd_din32, sd_dout32;
    logic [15:0]   cpu_din, sd_din;
    logic [1:0]    cpu_wdm, sd_wdm;
    logic          sd_rd, sd_wr, sd_refresh, sd_data_ready, sd_busy, sd_enabled;

    always #5 clk = ~clk;

    sdram_arbiter #(.FREQ(54_000_000), .REFRESH_INTERVAL(20), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_din32(cpu_din32),
        .cpu_wdm(cpu_wdm), .cpu_ack(cpu_ack), .cpu_data(cpu_data), .cpu_valid(cpu_valid),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_refresh(sd_refresh), .sd_addr(sd_addr), .sd_din(sd_din),
        .sd_din32(sd_din32), .sd_wdm(sd_wdm), .sd_dout32(sd_dout32), .sd_data_ready(sd_data_ready),
        .sd_busy(sd_busy), .sd_enabled(sd_enabled)
    );

    // Controller model: busy for 3 cycles after a command, read data on the third (T_RCD=1, CAS=2).
    logic [2:0]    m_cnt;
    logic          m_rd;
    logic [AW-1:0] m_addr;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt <= 3'd0; m_rd <= 1'b0; m_addr <= '0;
        end else if (sd_rd || sd_wr || sd_refresh) begin
            m_cnt <= 3'd3; m_rd <= sd_rd; m_addr <= sd_addr;
        end else if (m_cnt != 3'd0) begin
            m_cnt <= m_cnt - 3'd1;
        end
    end
    assign sd_busy       = m_cnt != 3'd0;
    assign sd_data_ready = m_rd && m_cnt == 3'd1;
    assign sd_dout32     = !sd_data_ready ? 32'h0BAD0BAD :
                           m_addr == 23'h000123 ? 32'hDEADBEEF : (32'hA5A50000 ^ {9'd0, m_addr});

    int tcnt;
    always @(posedge clk or posedge reset) begin
        if (reset) tcnt <= 0;
        else       tcnt <= (tcnt == 19) ? 0 : tcnt + 1;
    end

    cmd_t        q_vcmd[$], q_ccmd[$];
    logic [31:0] q_vid[$], q_cpu[$];
    int checks = 0, errors = 0;
    int cyc = 0, vid_ack_cyc = 0, cpu_ack_cyc = 0, last_cmd_cyc = -1000, n_ref = 0, mdebt = 0;
    bit vid_phase = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ctl"}, 64'({vid_ack, vid_valid, cpu_ack, cpu_valid, sd_rd, sd_wr, sd_refresh, sd_wdm}), 64'd0);
        chk({tag, "_vdata"}, 64'(vid_data), 64'd0);
        chk({tag, "_cdata"}, 64'(cpu_data), 64'd0);
        chk({tag, "_addr_din"}, 64'({sd_addr, sd_din}), 64'd0);
        chk({tag, "_din32"}, 64'(sd_din32), 64'd0);
    endtask

    initial begin
        cmd_t c;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                mdebt = 0;
                last_cmd_cyc = -1000;
                continue;
            end
            if (sd_refresh) begin
                n_ref++;
                chk("ref_has_debt", 64'(mdebt != 0), 64'd1);
                if (mdebt > 0) mdebt--;
                chk("ref_quiet", 64'({sd_busy, sd_rd, sd_wr, vid_ack, cpu_ack, !sd_enabled}), 64'd0);
                chk("ref_gap", 64'(cyc - last_cmd_cyc >= 6), 64'd1);
                last_cmd_cyc = cyc;
            end
            if (tcnt == 19) begin
                mdebt = (mdebt == 3) ? 3 : mdebt + 1;
                if (vid_phase) chk("debt_le1", 64'(mdebt <= 1), 64'd1);
            end
            if (sd_rd || sd_wr) begin
                chk("ack_onehot", 64'($onehot({vid_ack, cpu_ack})), 64'd1);
                chk("cmd_busy_en", 64'({sd_busy, sd_enabled}), 64'd1);
                chk("cmd_gap", 64'(cyc - last_cmd_cyc >= 6), 64'd1);
                last_cmd_cyc = cyc;
                if (vid_ack) begin
                    vid_ack_cyc = cyc;
                    if (q_vcmd.size() == 0) chk("vid_cmd_unexpected", 64'({sd_rd, sd_wr}), 64'd0);
                    else begin
                        c = q_vcmd.pop_front();
                        chk("vid_cmd_type", 64'({sd_rd, sd_wr}), 64'd2);
                        chk("vid_cmd_addr", 64'(sd_addr), 64'(c.addr));
                    end
                end
                if (cpu_ack) begin
                    cpu_ack_cyc = cyc;
                    if (q_ccmd.size() == 0) chk("cpu_cmd_unexpected", 64'({sd_rd, sd_wr}), 64'd0);
                    else begin
                        c = q_ccmd.pop_front();
                        chk("cpu_cmd_type", 64'({sd_rd, sd_wr}), c.we ? 64'd1 : 64'd2);
                        chk("cpu_cmd_addr", 64'(sd_addr), 64'(c.addr));
                        if (c.we) chk("cpu_wdata", 64'({sd_din, sd_din32, sd_wdm}), 64'({c.din, c.din32, c.wdm}));
                    end
                end
            end else if (vid_ack || cpu_ack) begin
                chk("stray_ack", 64'({vid_ack, cpu_ack}), 64'd0);
            end
            if (vid_valid) begin
                if (q_vid.size() == 0) chk("vid_valid_unexpected", 64'(vid_valid), 64'd0);
                else begin
                    chk("vid_data", 64'(vid_data), 64'(q_vid.pop_front()));
                    chk("vid_latency", 64'(cyc - vid_ack_cyc), 64'd4);
                end
            end
            if (cpu_valid) begin
                if (q_cpu.size() == 0) chk("cpu_valid_unexpected", 64'(cpu_valid), 64'd0);
                else begin
                    chk("cpu_data", 64'(cpu_data), 64'(q_cpu.pop_front()));
                    chk("cpu_latency", 64'(cyc - cpu_ack_cyc), 64'd4);
                end
            end
        end
    end

    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [15:0] d,
                          input logic [31:0] d32, input logic [1:0] m, input logic [31:0] exp_rd);
        int n = 0;
        q_ccmd.push_back({we, a, d, d32, m});
        if (!we) q_cpu.push_back(exp_rd);
        cpu_we = we; cpu_addr = a; cpu_din = d; cpu_din32 = d32; cpu_wdm = m; cpu_req = 1'b1;
        do begin @(negedge clk); n++; end while (!cpu_ack && n < 300);
        if (!cpu_ack) chk("cpu_ack_timeout", 64'(cpu_ack), 64'd1);
        @(posedge clk); #1 cpu_req = 1'b0;
    endtask

    task automatic vid_op(input logic [AW-1:0] a, input logic [31:0] exp_rd, input bit expect_data);
        int n = 0;
        q_vcmd.push_back({1'b0, a, 16'd0, 32'd0, 2'd0});
        if (expect_data) q_vid.push_back(exp_rd);
        vid_addr = a; vid_req = 1'b1;
        do begin @(negedge clk); n++; end while (!vid_ack && n < 300);
        if (!vid_ack) chk("vid_ack_timeout", 64'(vid_ack), 64'd1);
        @(posedge clk); #1 vid_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        int bad, n0;
        reset = 1'b1;
        vid_req = 0; vid_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0;
        cpu_din = '0; cpu_din32 = '0; cpu_wdm = '0; sd_enabled = 0;
        repeat (2) @(posedge clk);
        #1 check_zero_outputs("reset");
        reset = 1'b0;
        // Controller not yet enabled: CPU read must wait, then issue with ack
        bad = 0;
        fork
            cpu_op(1'b0, 23'h000123, 16'h0, 32'h0, 2'b00, 32'hDEADBEEF);
            begin
                repeat (100) begin @(negedge clk); if (sd_rd || sd_wr || sd_refresh) bad++; end
                chk("disabled_quiet", 64'(bad), 64'd0);
                sd_enabled = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        cpu_op(1'b1, 23'h000201, 16'h55AA, 32'h12345678, 2'b01, 32'h0);
        cpu_op(1'b1, 23'h000202, 16'h0000, 32'hCAFEF00D, 2'b00, 32'h0);
        cpu_op(1'b0, 23'h000300, 16'h0, 32'h0, 2'b00, 32'hA5A50300);
        repeat (8) @(posedge clk);
        // Simultaneous requests: video wins
        fork
            vid_op(23'h000400, 32'hA5A50400, 1'b1);
            cpu_op(1'b0, 23'h000404, 16'h0, 32'h0, 2'b00, 32'hA5A50404);
        join
        chk("vid_before_cpu", 64'(vid_ack_cyc < cpu_ack_cyc), 64'd1);
        chk("cpu_after_busy", 64'(cpu_ack_cyc - vid_ack_cyc >= 6), 64'd1);
        repeat (10) @(posedge clk);
        // Idle refresh cadence
        do_reset();
        n0 = n_ref;
        repeat (210) @(posedge clk);
        chk("refresh_count", 64'(n_ref - n0), 64'd10);
        // Back-to-back video with refresh preemption
        do_reset();
        vid_phase = 1;
        n0 = n_ref;
        for (int i = 0; i < 14; i++) vid_op(23'h000800 + 23'(4 * i), 32'hA5A50800 + 32'(4 * i), 1'b1);
        repeat (8) @(posedge clk);
        chk("vid_phase_refreshes", 64'(n_ref - n0 >= 4), 64'd1);
        // Reset while a video read is in flight
        vid_op(23'h000500, 32'h0, 1'b0);
        vid_phase = 0;
        reset = 1'b1;
        #1 check_zero_outputs("midreset");
        @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        chk("queues_drained", 64'(q_vcmd.size() + q_ccmd.size() + q_vid.size() + q_cpu.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end
endmodule
